// File: rtl/cmos_frame_packer_if.sv
// Camera DVP input bus and DDR write-side outputs of the frame packer.
// master = the packer itself, slave = the surrounding sensor/DDR environment.
interface cmos_frame_packer_if;
  logic        camera_vsync;
  logic        camera_href;
  logic [7:0]  camera_data;
  logic        ddr_wren;
  logic [31:0] ddr_data;
  logic        data_valid_wr;
  logic        frame_switch;
  logic        frame_done;
  logic        frame_err;
  logic        line_err;

  modport master (
    input  camera_vsync, camera_href, camera_data,
    output ddr_wren, ddr_data, data_valid_wr, frame_switch, frame_done,
           frame_err, line_err
  );

  modport slave (
    output camera_vsync, camera_href, camera_data,
    input  ddr_wren, ddr_data, data_valid_wr, frame_switch, frame_done,
           frame_err, line_err
  );
endinterface

// File: rtl/cmos_frame_packer.sv
// OV5640 DVP to DDR write packer: skips startup frames, packs two RGB565 pixels
// per 32-bit word and flags frames/lines whose geometry does not match.
module cmos_frame_packer #(
  parameter int H_ACTIVE   = 1024,
  parameter int V_ACTIVE   = 768,
  parameter int FRAME_SKIP = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 init_done,
  cmos_frame_packer_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_SKIP = 2'd2,
    ST_CAP  = 2'd3
  } state_t;

  localparam logic [19:0] WORDS_EXP = 20'(H_ACTIVE * V_ACTIVE / 2);
  localparam logic [11:0] LINES_EXP = 12'(V_ACTIVE);
  localparam logic [7:0]  SKIP_TGT  = 8'(FRAME_SKIP);
  localparam logic [19:0] WORD_MAX  = {20{1'b1}};
  localparam logic [11:0] LINE_MAX  = {12{1'b1}};

  state_t      state_r, state_nxt_s;
  logic        vsync_s1_r, href_s1_r, vsync_s2_r, href_s2_r;
  logic [7:0]  data_s1_r;
  logic [7:0]  skip_cnt_r;
  logic [1:0]  byte_idx_r;
  logic [23:0] word_sr_r;
  logic [19:0] word_cnt_r, word_cnt_nxt_s;
  logic [11:0] line_cnt_r, line_cnt_nxt_s;
  logic        word_ovf_r, word_ovf_nxt_s, line_ovf_r, line_ovf_nxt_s;
  logic        ddr_wren_r, data_valid_r, frame_switch_r, frame_done_r;
  logic        frame_err_r, line_err_r;
  logic [31:0] ddr_data_r;
  logic        vs_fall_s, vs_rise_s, href_fall_s, skip_hit_s;
  logic        frame_switch_s, frame_done_s, capture_s, strobe_s, line_end_s;
  logic        count_bad_s;

  assign vs_fall_s   = vsync_s2_r & ~vsync_s1_r;
  assign vs_rise_s   = ~vsync_s2_r & vsync_s1_r;
  assign href_fall_s = href_s2_r & ~href_s1_r;
  assign skip_hit_s  = (skip_cnt_r + 8'd1) == SKIP_TGT;

  // Input capture register and the delayed copy used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_s1_r <= 1'b0;
      href_s1_r  <= 1'b0;
      data_s1_r  <= 8'd0;
      vsync_s2_r <= 1'b0;
      href_s2_r  <= 1'b0;
    end else begin
      vsync_s1_r <= bus.camera_vsync;
      href_s1_r  <= bus.camera_href;
      data_s1_r  <= bus.camera_data;
      vsync_s2_r <= vsync_s1_r;
      href_s2_r  <= href_s1_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; losing init_done always returns to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    if (!init_done) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_nxt_s = ST_SYNC;
        ST_SYNC: begin
          if (vs_fall_s) begin
            state_nxt_s = (SKIP_TGT == 8'd0) ? ST_CAP : ST_SKIP;
          end else begin
            state_nxt_s = ST_SYNC;
          end
        end
        ST_SKIP: begin
          if (vs_fall_s && skip_hit_s) begin
            state_nxt_s = ST_CAP;
          end else begin
            state_nxt_s = ST_SKIP;
          end
        end
        ST_CAP:  state_nxt_s = ST_CAP;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // FSM outputs; a byte arriving on the frame-start cycle is not packed so
  // every frame begins on a word boundary.
  always_comb begin
    frame_switch_s = 1'b0;
    frame_done_s   = 1'b0;
    capture_s      = 1'b0;
    line_end_s     = 1'b0;
    if (init_done) begin
      case (state_r)
        ST_SYNC: frame_switch_s = vs_fall_s & (SKIP_TGT == 8'd0);
        ST_SKIP: frame_switch_s = vs_fall_s & skip_hit_s;
        ST_CAP: begin
          frame_switch_s = vs_fall_s;
          frame_done_s   = vs_rise_s;
          capture_s      = href_s1_r & ~vsync_s1_r & ~vs_fall_s;
          line_end_s     = href_fall_s;
        end
        default: frame_switch_s = 1'b0;
      endcase
    end else begin
      frame_switch_s = 1'b0;
    end
  end

  assign strobe_s = capture_s & (byte_idx_r == 2'd3);

  // Saturating frame counters as they will be after this cycle, so a word or
  // line closing on the frame-end cycle is included in the check.
  always_comb begin
    word_cnt_nxt_s = word_cnt_r;
    word_ovf_nxt_s = word_ovf_r;
    line_cnt_nxt_s = line_cnt_r;
    line_ovf_nxt_s = line_ovf_r;
    if (strobe_s) begin
      if (word_cnt_r == WORD_MAX) begin
        word_ovf_nxt_s = 1'b1;
      end else begin
        word_cnt_nxt_s = word_cnt_r + 20'd1;
      end
    end else begin
      word_cnt_nxt_s = word_cnt_r;
    end
    if (line_end_s) begin
      if (line_cnt_r == LINE_MAX) begin
        line_ovf_nxt_s = 1'b1;
      end else begin
        line_cnt_nxt_s = line_cnt_r + 12'd1;
      end
    end else begin
      line_cnt_nxt_s = line_cnt_r;
    end
    count_bad_s = (word_cnt_nxt_s != WORDS_EXP) | (line_cnt_nxt_s != LINES_EXP)
                | word_ovf_nxt_s | line_ovf_nxt_s;
  end

  // Packing datapath, frame counters, sticky flags and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_cnt_r     <= 8'd0;
      byte_idx_r     <= 2'd0;
      word_sr_r      <= 24'd0;
      word_cnt_r     <= 20'd0;
      word_ovf_r     <= 1'b0;
      line_cnt_r     <= 12'd0;
      line_ovf_r     <= 1'b0;
      ddr_wren_r     <= 1'b0;
      ddr_data_r     <= 32'd0;
      data_valid_r   <= 1'b0;
      frame_switch_r <= 1'b0;
      frame_done_r   <= 1'b0;
      frame_err_r    <= 1'b0;
      line_err_r     <= 1'b0;
    end else begin
      if (state_r == ST_SKIP && init_done && vs_fall_s) begin
        skip_cnt_r <= skip_cnt_r + 8'd1;
      end else if (state_r != ST_SKIP) begin
        skip_cnt_r <= 8'd0;
      end

      if (state_r != ST_CAP || !init_done || vs_fall_s || line_end_s) begin
        byte_idx_r <= 2'd0;
      end else if (capture_s) begin
        byte_idx_r <= byte_idx_r + 2'd1;
      end

      if (capture_s) begin
        word_sr_r <= {word_sr_r[15:0], data_s1_r};
      end

      ddr_wren_r <= strobe_s;
      if (strobe_s) begin
        ddr_data_r <= {word_sr_r, data_s1_r};
      end

      if (frame_switch_s) begin
        word_cnt_r <= 20'd0;
        word_ovf_r <= 1'b0;
        line_cnt_r <= 12'd0;
        line_ovf_r <= 1'b0;
      end else begin
        word_cnt_r <= word_cnt_nxt_s;
        word_ovf_r <= word_ovf_nxt_s;
        line_cnt_r <= line_cnt_nxt_s;
        line_ovf_r <= line_ovf_nxt_s;
      end

      if (!init_done) begin
        data_valid_r <= 1'b0;
      end else if (frame_switch_s) begin
        data_valid_r <= 1'b1;
      end else if (frame_done_s) begin
        data_valid_r <= 1'b0;
      end

      frame_switch_r <= frame_switch_s;
      frame_done_r   <= frame_done_s;

      if (line_end_s && byte_idx_r != 2'd0) begin
        line_err_r <= 1'b1;
      end
      if (frame_done_s && count_bad_s) begin
        frame_err_r <= 1'b1;
      end
    end
  end

  assign bus.ddr_wren      = ddr_wren_r;
  assign bus.ddr_data      = ddr_data_r;
  assign bus.data_valid_wr = data_valid_r;
  assign bus.frame_switch  = frame_switch_r;
  assign bus.frame_done    = frame_done_r;
  assign bus.frame_err     = frame_err_r;
  assign bus.line_err      = line_err_r;

endmodule
